// File: rtl/pwm_pkg.sv
// Shared PWM definitions: control-word bit positions, the default-width
// counter type and the run/idle state of the generator.
package pwm_pkg;

  // Control word bit positions.
  localparam int PWM_CTRL_EN_BIT  = 0;
  localparam int PWM_CTRL_INV_BIT = 1;

  // Default counter width and its matching type, used by register-block
  // code that talks to a default-configured generator.
  localparam int PWM_CNT_W = 16;
  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

  // IDLE: enable was low last cycle, so the next enabled cycle starts a
  // fresh period and loads the shadows. RUN: a period is in progress.
  typedef enum logic {
    PWM_IDLE = 1'b0,
    PWM_RUN  = 1'b1
  } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_gen.sv
// PWM generator with shadowed period/duty, registered waveform, one-cycle
// period-end pulse and an optional sticky interrupt flag.
// Optional feature: define PWM_GEN_IRQ_EN to implement the irq flag;
// without it irq is tied low and irq_clr is ignored.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int CTRL_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  input  logic [CNT_WIDTH-1:0]  period,
  input  logic [CNT_WIDTH-1:0]  duty,
  output logic                  pwm_out,
  output logic                  period_end,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  irq,
  input  logic                  irq_clr
);

  // Decoded control bits; invert is used live, never shadowed.
  logic en;
  logic inv;

  // Registered state and next-state values.
  pwm_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] period_sh_q, period_sh_d;
  logic [CNT_WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic                 pwm_q, pwm_d;
  logic                 pe_q, pe_d;

  // Values the counter and comparator act on this cycle.
  logic                 start;
  logic                 at_term;
  logic                 load;
  logic [CNT_WIDTH-1:0] cur_period;
  logic [CNT_WIDTH-1:0] cur_duty;

  assign en  = ctrl[PWM_CTRL_EN_BIT];
  assign inv = ctrl[PWM_CTRL_INV_BIT];

  // Next-state logic for counter, shadows, waveform and period-end pulse.
  always_comb begin
    // NOTE: every signal written here gets a value on every path (defaults
    // first), otherwise synthesis would infer a latch to hold the old value.
    state_d     = en ? PWM_RUN : PWM_IDLE;
    start       = en && (state_q == PWM_IDLE);

    // In the first enabled cycle the shadows are being loaded at this very
    // edge, so the period starting now must already use the incoming
    // values; otherwise count 0 of a fresh period would be compared
    // against stale shadows.
    cur_period  = start ? period : period_sh_q;
    cur_duty    = start ? duty   : duty_sh_q;

    at_term     = (count_q == cur_period);
    load        = start || (en && at_term);

    period_sh_d = load ? period : period_sh_q;
    duty_sh_d   = load ? duty   : duty_sh_q;

    // Disabled: counter parked at 0 and waveform at the inactive level.
    // A zero period keeps count at 0 because every cycle is terminal.
    count_d     = '0;
    pwm_d       = inv;
    pe_d        = 1'b0;
    if (en) begin
      if (!at_term) begin
        count_d = count_q + 1'b1;
      end
      // count never exceeds cur_period, so duty > period means always
      // active and duty == 0 means never active.
      pwm_d = (count_q < cur_duty) ^ inv;
      pe_d  = at_term;
    end
  end

  // Register update with synchronous reset to an idle, zeroed generator.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the
    // pre-edge values, so the order of these statements cannot matter.
    if (reset) begin
      state_q     <= PWM_IDLE;
      count_q     <= '0;
      period_sh_q <= '0;
      duty_sh_q   <= '0;
      pwm_q       <= 1'b0;
      pe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      pwm_q       <= pwm_d;
      pe_q        <= pe_d;
    end
  end

  assign count      = count_q;
  assign pwm_out    = pwm_q;
  assign period_end = pe_q;

`ifdef PWM_GEN_IRQ_EN
  logic irq_q, irq_d;

  // Sticky flag: a period-end pulse sets it even when irq_clr arrives in
  // the same cycle, so an event is never lost to a coincident read.
  always_comb begin
    irq_d = pe_q | (irq_q & ~irq_clr);
  end

  // Interrupt flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

  // Only the enable and invert bits of the control word are meaningful.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl;
`else
  assign irq = 1'b0;

  // Without the flag the clear strobe has nothing to act on; only the
  // enable and invert bits of the control word are meaningful.
  logic unused_inputs;
  assign unused_inputs = ^{ctrl, irq_clr};
`endif

endmodule : pwm_gen

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, giving the counter, period and duty width in bits.
REQ-002 SHALL have parameter CTRL_WIDTH, default 32, giving the control word width, matched to the register block driving it.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ctrl, input, CTRL_WIDTH bits: bit0 enable, bit1 invert polarity; other bits ignored.
REQ-006 SHALL have port period, input, CNT_WIDTH bits: terminal count; the PWM period is period+1 cycles.
REQ-007 SHALL have port duty, input, CNT_WIDTH bits: number of active cycles per period.
REQ-008 SHALL have port pwm_out, output, 1 bit: registered PWM waveform.
REQ-009 SHALL have port period_end, output, 1 bit: one-cycle pulse at the terminal count.
REQ-010 SHALL have port count, output, CNT_WIDTH bits: current counter value, for a read-only register.
REQ-011 SHALL have port irq, output, 1 bit: sticky period-end flag.
REQ-012 SHALL have port irq_clr, input, 1 bit: clears irq; driven by the read strobe of the read-only register.

Function
REQ-013 SHALL keep period_sh and duty_sh shadow registers; the counter and comparator SHALL use only the shadows.
REQ-014 SHALL load the shadows from period and duty in the first cycle enable is seen high after being low, and in each cycle where count==period_sh while enabled.
REQ-015 SHALL, while enabled, increment count each cycle and wrap to 0 in the cycle after count==period_sh.
REQ-016 SHALL, when period_sh==0, hold count at 0 and pulse period_end every cycle.
REQ-017 SHALL set pwm_out, one cycle after count is valid, to (count<duty_sh) XOR invert.
REQ-018 SHALL drive pwm_out constantly active when duty_sh>period_sh, and constantly inactive when duty_sh==0.
REQ-019 SHALL take invert directly from ctrl without shadowing; a change SHALL appear on pwm_out in the next cycle.
REQ-020 SHALL assert period_end for exactly the cycles where enable is high and count==period_sh, registered with the same latency as pwm_out.
REQ-021 SHALL, on enable deasserting mid-period, force count to 0, pwm_out to the inactive level (invert) and period_end low on the next edge, with no partial-period pulse.
REQ-022 SHALL ignore changes to period and duty mid-period; they take effect only at the next shadow load.

Reset
REQ-023 SHALL, while reset is high at an edge, set count, period_sh, duty_sh, pwm_out, period_end and irq to 0, regardless of ctrl.
REQ-024 SHALL start the first period after reset deassertion from count 0, with a shadow load if enable is high.

Configuration
REQ-025 SHALL implement the irq flag only when the macro PWM_GEN_IRQ_EN is defined; irq SHALL set on period_end and clear on irq_clr.
REQ-026 SHALL give set priority over clear when period_end and irq_clr coincide.
REQ-027 SHALL, with PWM_GEN_IRQ_EN undefined, tie irq to 0, ignore irq_clr, and leave all other behaviour unchanged.

Structure
REQ-028 SHALL take from the shared package pwm_pkg the constants PWM_CTRL_EN_BIT=0 and PWM_CTRL_INV_BIT=1, plus the typedef pwm_cnt_t.
REQ-029 SHALL be a single module with no sub-modules; the counter, shadows, comparator and irq flag are implemented inline.

Verification
REQ-030 Period=9, duty=3, enable=1 -> pwm_out high 3 of every 10 cycles; period_end pulses every 10th cycle; count runs 0..9.
REQ-031 Change duty 3->7 while count=4 -> the current period stays at 3 high cycles; the next period has 7.
REQ-032 Duty=0 gives pwm_out stuck low; duty=12 with period=9 gives pwm_out stuck high; setting invert=1 inverts both on the next cycle.
REQ-033 Clear enable at count=5 -> next cycle count=0, pwm_out=invert, no period_end; re-enable loads new shadows and starts at count 0.
REQ-034 With PWM_GEN_IRQ_EN defined: irq sets on period_end; irq_clr alone clears it; irq_clr in the same cycle as period_end leaves irq=1. With the macro undefined, irq stays 0 throughout.
REQ-035 Assert reset mid-period with enable=1 -> after the edge all outputs are 0; after release, count restarts at 0.
